serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial ripple-borrow subtractor, the inverse-operation counterpart of the team's ripple-carry adder datapath. It computes Diff = A − B − Bin by processing one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop. A start/busy/done handshake makes it usable as a multi-cycle arithmetic unit beside the combinational adders.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- Bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result is valid
- Diff  output  WIDTH  result, held until the next accepted start
- Bout  output  1  final borrow-out (1 ⇔ A < B + Bin, unsigned)
- Ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE: start=1 → capture A, B, Bin into operand shift registers and borrow FF, clear bit counter, go to SHIFT. start=0 in DONE → IDLE.
- SHIFT: per cycle, with a=A_reg[0], b=B_reg[0], br=borrow FF: d = a^b^br; br_next = (~a&b) | (~(a^b)&br). d shifts into Diff MSB (Diff shifts right); A_reg/B_reg shift right; counter increments. After bit WIDTH−1, go to DONE; Bout ← final br_next.
- DONE: done=1 for exactly this cycle; Diff/Bout stable.
- start while busy: ignored, no effect on operands or result.
- Diff/Bout are only updated on the final SHIFT edge; intermediate shifting happens in an internal register, so outputs never show partial results.
- Arithmetic: modulo 2^WIDTH; Diff equals (A − B − Bin) mod 2^WIDTH; Bout is the unsigned borrow.

## Timing
- Reset (async assert, synchronous release to clk): state=IDLE, busy=0, done=0, Diff=0, Bout=0, Ovf=0, internal registers 0.
- Latency: start accepted at edge k → SHIFT on edges k+1…k+WIDTH → done high during cycle after edge k+WIDTH (WIDTH+1 cycles start-to-done).
- busy=1 exactly during SHIFT (WIDTH cycles).
- Back-to-back: start=1 in the DONE cycle is accepted; busy rises next cycle; throughput one result per WIDTH+1 cycles.
- Reset mid-SHIFT: operation aborted, no done pulse, outputs return to reset values immediately.

## Configuration
- SERIAL_SUB_OVF_EN defined: Ovf port exists; on the final SHIFT edge Ovf ← (A[MSB] ≠ B[MSB]) & (Diff[MSB] ≠ A[MSB]) using captured operand MSBs; held with Diff, reset to 0.
- Undefined: no Ovf port, no MSB capture logic; all other behaviour identical.

## Structure
- Package serial_subtractor_pkg: state enum (IDLE, SHIFT, DONE), default WIDTH constant, counter width as $clog2(WIDTH).
- Sub-module full_subtractor_bit: combinational 1-bit cell (a, b, bin → d, bout); instantiated once, fed by the shift registers.

## Test plan
- A=9, B=3, Bin=0, start 1 cycle → done after 5 cycles, Diff=6, Bout=0, busy high 4 cycles.
- A=3, B=9, Bin=0 → Diff=4'b1010, Bout=1.
- A=5, B=5, Bin=1 → Diff=4'b1111, Bout=1; A=0, B=0, Bin=0 → Diff=0, Bout=0.
- Start A=9,B=3; pulse start with A=1,B=1 during busy → ignored, Diff=6; second start in DONE cycle with A=15,B=1 → next Diff=14, no gap cycle.
- Assert rst two cycles into SHIFT → busy/done/Diff/Bout all 0 immediately, no done pulse; new start after release completes normally.
- With SERIAL_SUB_OVF_EN: A=4'b0111, B=4'b1000 → Diff=4'b1111, Ovf=1; A=6, B=2 → Ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial ripple-borrow subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, bout = borrow.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock through a single cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Handshake: start is accepted on any edge where state is not SHIFT;
  // busy is high exactly during SHIFT, done pulses for the single DONE cycle.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last;

  assign accept = start && (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == LAST_BIT);

  full_subtractor_bit u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Partial results live in work; Diff/Bout only change on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      work   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
    end else if (accept) begin
      a_reg  <= A;
      b_reg  <= B;
      work   <= '0;
      cnt    <= '0;
      borrow <= Bin;
    end else if (state == SHIFT) begin
      a_reg  <= a_reg >> 1;
      b_reg  <= b_reg >> 1;
      work   <= {cell_d, work[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      borrow <= cell_bout;
      if (last) begin
        Diff <= {cell_d, work[WIDTH-1:1]};
        Bout <= cell_bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end else if (last) begin
      Ovf <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a scoreboard of expected results.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int n;
  logic [W+1:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {ovf, bout, diff} computed from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int r;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    r  = int'(a) - int'(b) - int'(bin);
    d  = r[W-1:0];
    bo = (r < 0);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {ov, bo, d};
  endfunction

  // driver: call at a negedge where the DUT will accept start
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a;
    B = b;
    Bin = bin;
    start = 1'b1;
    exp_q.push_back(model(a, b, bin));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 40);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("busy_cycles", busy_cnt, W);
        busy_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("diff", Diff, e[W-1:0]);
          check("bout", Bout, e[W]);
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", Ovf, e[W+1]);
`endif
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ta [4] = '{4'd9, 4'd3, 4'd5, 4'd0};
    logic [W-1:0] tb [4] = '{4'd3, 4'd9, 4'd5, 4'd0};
    logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", Diff, 0);
    check("rst_bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", Ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // directed table: 9-3, 3-9, 5-5-1, 0-0
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], tc[i]);
      wait_done(n);
      check("latency", n, W + 1);
      @(negedge clk);
      check("idle_after_done", {busy, done}, 0);
    end

    // random operands
    for (int i = 0; i < 10; i++) begin
      launch(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_done(n);
      check("rand_latency", n, W + 1);
      @(negedge clk);
    end

    // start during busy ignored, then back-to-back start in DONE cycle
    launch(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    A = 4'd1;
    B = 4'd1;
    Bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignored_diff", Diff, 4'd6);
    launch(4'd15, 4'd1, 1'b0);
    check("b2b_busy", busy, 1);
    wait_done(n);
    check("b2b_latency", n, W + 1);
    repeat (3) @(negedge clk);
    check("diff_held", Diff, 4'd14);

    // reset two cycles into SHIFT
    launch(4'd7, 4'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", Diff, 0);
    check("abort_bout", Bout, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    launch(4'd12, 4'd5, 1'b1);
    wait_done(n);
    check("post_abort_latency", n, W + 1);
    @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
    launch(4'b0111, 4'b1000, 1'b0);
    wait_done(n);
    check("ovf_set", Ovf, 1);
    @(negedge clk);
    launch(4'd6, 4'd2, 1'b0);
    wait_done(n);
    check("ovf_clr", Ovf, 0);
    @(negedge clk);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
